// File: rtl/conv_window_sequencer.sv
// Streaming KxK window generator: raster pixels in, stride-aware legal windows out with grid coordinates.
// Optional CONV_SEQ_STATS_EN adds saturating stall/window handshake counters.
module conv_window_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int N_COLS      = 160,
    parameter int N_ROWS      = 108,
    parameter int KERNEL_SIZE = 3,
    parameter int STEP_SIZE   = 1,
    parameter int CONTINUOUS  = 1,
    localparam int OUT_COLS   = (N_COLS - KERNEL_SIZE) / STEP_SIZE + 1,
    localparam int OUT_ROWS   = (N_ROWS - KERNEL_SIZE) / STEP_SIZE + 1,
    localparam int OCW        = $clog2(OUT_COLS) + 1,
    localparam int ORW        = $clog2(OUT_ROWS) + 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic                                       clear_i,
    input  logic [DATA_WIDTH-1:0]                      data_i,
    input  logic                                       valid_i,
    output logic                                       ready_o,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_o,
    output logic                                       valid_o,
    input  logic                                       ready_i,
    output logic [OCW-1:0]                             out_col_o,
    output logic [ORW-1:0]                             out_row_o,
    output logic                                       last_o,
`ifdef CONV_SEQ_STATS_EN
    output logic [31:0]                                stall_cnt_o,
    output logic [31:0]                                win_cnt_o,
`endif
    output logic                                       done_o
);
    localparam int K  = KERNEL_SIZE;
    localparam int S  = STEP_SIZE;
    localparam int CW = $clog2(N_COLS);
    localparam int RW = $clog2(N_ROWS);

    typedef enum logic [1:0] {S_FILL, S_RUN, S_DONE} state_t;
    state_t state_q, state_d;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept, emit, in_grid, last_pix, fill_pix;
    int            r_off, c_off;

    logic [DATA_WIDTH-1:0] lb      [K-1][N_COLS];  // lb[0] = previous row, lb[j] = j+1 rows back
    logic [DATA_WIDTH-1:0] win     [K][K];
    logic [DATA_WIDTH-1:0] nwin    [K][K];
    logic [DATA_WIDTH-1:0] col_vec [K];
    logic [K*K*DATA_WIDTH-1:0] nwin_flat;

    assign accept   = valid_i & ready_o & ~clear_i;
    assign last_pix = (row == RW'(N_ROWS - 1)) && (col == CW'(N_COLS - 1));
    assign fill_pix = (row == RW'(K - 1)) && (col == CW'(K - 1));

    assign r_off   = int'(row) - (K - 1);
    assign c_off   = int'(col) - (K - 1);
    assign in_grid = (r_off >= 0) && (c_off >= 0) && (r_off % S == 0) && (c_off % S == 0) &&
                     (r_off / S < OUT_ROWS) && (c_off / S < OUT_COLS);
    assign emit    = accept & in_grid;

    // Incoming column: oldest line-buffer row on top, live pixel at the bottom.
    always_comb begin
        col_vec[K-1] = data_i;
        for (int ky = 0; ky < K - 1; ky++)
            col_vec[ky] = lb[K-2-ky][col];
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                nwin[ky][kx] = (kx == K - 1) ? col_vec[ky] : win[ky][kx+1];
        nwin_flat = '0;
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                nwin_flat[(ky*K+kx)*DATA_WIDTH +: DATA_WIDTH] = nwin[ky][kx];
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb[0][col] <= data_i;
            for (int j = 1; j < K - 1; j++)
                lb[j][col] <= lb[j-1][col];
            win <= nwin;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_FILL;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready_o = (state_q != S_DONE) & (~valid_o | ready_i);
        if (clear_i) begin
            state_d = S_FILL;
        end else if (accept) begin
            if (last_pix)
                state_d = (CONTINUOUS != 0) ? S_FILL : S_DONE;
            else if (state_q == S_FILL && fill_pix)
                state_d = S_RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col <= '0;
            row <= '0;
        end else if (clear_i) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == CW'(N_COLS - 1)) begin
                col <= '0;
                row <= last_pix ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // A new window can only load when the output slot is free, so no overwrite check is needed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            window_o  <= '0;
            out_col_o <= '0;
            out_row_o <= '0;
        end else if (clear_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
        end else if (emit) begin
            valid_o   <= 1'b1;
            window_o  <= nwin_flat;
            out_col_o <= OCW'(c_off / S);
            out_row_o <= ORW'(r_off / S);
            last_o    <= (c_off / S == OUT_COLS - 1) && (r_off / S == OUT_ROWS - 1);
        end else if (ready_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
        end
    end

    assign done_o = valid_o & ready_i & last_o;

`ifdef CONV_SEQ_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_o <= '0;
            win_cnt_o   <= '0;
        end else if (clear_i) begin
            stall_cnt_o <= '0;
            win_cnt_o   <= '0;
        end else begin
            if (valid_o && !ready_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
            if (valid_o && ready_i && win_cnt_o != '1)    win_cnt_o   <= win_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer on an 8x6 image, K=3: S=1 continuous, S=2 continuous, S=1 one-shot.
module tb_conv_window_sequencer;
    localparam int DW = 32, NC = 8, NR = 6, K = 3, KK = K * K;
    localparam int OC0 = (NC - K) / 1 + 1, OR0 = (NR - K) / 1 + 1;
    localparam int OC1 = (NC - K) / 2 + 1, OR1 = (NR - K) / 2 + 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic vi [3], ri [3], cl [3], ro [3], vo [3], lo [3], dn [3];
    logic [DW-1:0]    di [3];
    logic [KK*DW-1:0] wo [3];
    logic [$clog2(OC0):0] oc0, oc2;
    logic [$clog2(OR0):0] or0, or2;
    logic [$clog2(OC1):0] oc1;
    logic [$clog2(OR1):0] or1;
`ifdef CONV_SEQ_STATS_EN
    logic [31:0] sc [3], wc [3];
`endif

    conv_window_sequencer #(.DATA_WIDTH(DW), .N_COLS(NC), .N_ROWS(NR), .KERNEL_SIZE(K), .STEP_SIZE(1), .CONTINUOUS(1)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(cl[0]), .data_i(di[0]), .valid_i(vi[0]), .ready_o(ro[0]),
        .window_o(wo[0]), .valid_o(vo[0]), .ready_i(ri[0]), .out_col_o(oc0), .out_row_o(or0), .last_o(lo[0]),
`ifdef CONV_SEQ_STATS_EN
        .stall_cnt_o(sc[0]), .win_cnt_o(wc[0]),
`endif
        .done_o(dn[0]));
    conv_window_sequencer #(.DATA_WIDTH(DW), .N_COLS(NC), .N_ROWS(NR), .KERNEL_SIZE(K), .STEP_SIZE(2), .CONTINUOUS(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(cl[1]), .data_i(di[1]), .valid_i(vi[1]), .ready_o(ro[1]),
        .window_o(wo[1]), .valid_o(vo[1]), .ready_i(ri[1]), .out_col_o(oc1), .out_row_o(or1), .last_o(lo[1]),
`ifdef CONV_SEQ_STATS_EN
        .stall_cnt_o(sc[1]), .win_cnt_o(wc[1]),
`endif
        .done_o(dn[1]));
    conv_window_sequencer #(.DATA_WIDTH(DW), .N_COLS(NC), .N_ROWS(NR), .KERNEL_SIZE(K), .STEP_SIZE(1), .CONTINUOUS(0)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(cl[2]), .data_i(di[2]), .valid_i(vi[2]), .ready_o(ro[2]),
        .window_o(wo[2]), .valid_o(vo[2]), .ready_i(ri[2]), .out_col_o(oc2), .out_row_o(or2), .last_o(lo[2]),
`ifdef CONV_SEQ_STATS_EN
        .stall_cnt_o(sc[2]), .win_cnt_o(wc[2]),
`endif
        .done_o(dn[2]));

    typedef struct { int row; int col; logic last; logic [KK*DW-1:0] win; } exp_t;
    typedef struct { int d; int rmode; int vmode; int npix; int nwin; int e8_first; int e8_last; int ndone; } vec_t;

    exp_t expq[$];
    int   pass_cnt = 0, chk_cnt = 0;
    int   nwin, first_e0, first_e8, last_e8, done_cnt;
    logic [KK*DW-1:0] held;
    bit   stalled_prev, check_en;

    task automatic chk(input string nm, input logic [KK*DW-1:0] act, input logic [KK*DW-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int orow(input int d);
        case (d)
            0: return int'(or0);
            1: return int'(or1);
            default: return int'(or2);
        endcase
    endfunction

    function automatic int ocol(input int d);
        case (d)
            0: return int'(oc0);
            1: return int'(oc1);
            default: return int'(oc2);
        endcase
    endfunction

    // Reference: every legal output grid point, window read straight from the raster image (pixel = r*NC+c).
    task automatic build(input int d, input int frames);
        int s, ocn, orn;
        exp_t e;
        s   = (d == 1) ? 2 : 1;
        ocn = (NC - K) / s + 1;
        orn = (NR - K) / s + 1;
        for (int f = 0; f < frames; f++)
            for (int r = 0; r < orn; r++)
                for (int c = 0; c < ocn; c++) begin
                    e.row  = r;
                    e.col  = c;
                    e.last = (r == orn - 1) && (c == ocn - 1);
                    e.win  = '0;
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++)
                            e.win[(ky*K+kx)*DW +: DW] = DW'((r * s + ky) * NC + c * s + kx);
                    expq.push_back(e);
                end
    endtask

    task automatic mon(input int d);
        exp_t e;
        logic [KK*DW-1:0] w;
        w = wo[d];
        if (stalled_prev) begin
            chk("hold_valid", vo[d], 1'b1);
            chk("hold_window", w, held);
        end
        if (vo[d] && !ri[d]) chk("stall_ready_o", ro[d], 1'b0);
        if (vo[d] && ri[d]) begin
            nwin++;
            if (nwin == 1) begin
                first_e0 = int'(w[0 +: DW]);
                first_e8 = int'(w[8*DW +: DW]);
            end
            last_e8 = int'(w[8*DW +: DW]);
            if (dn[d]) done_cnt++;
            if (check_en) begin
                if (expq.size() == 0) chk("extra_window", 1'b1, 1'b0);
                else begin
                    e = expq.pop_front();
                    chk("window", w, e.win);
                    chk("out_row", orow(d), e.row);
                    chk("out_col", ocol(d), e.col);
                    chk("last_o", lo[d], e.last);
                    chk("done_o", dn[d], e.last);
                end
            end
        end else if (check_en) chk("done_idle", dn[d], 1'b0);
        stalled_prev = vo[d] && !ri[d];
        held = w;
    endtask

    // rmode 0: ready_i=1, 1: toggle, 2: random ~75%.  vmode 0: valid_i=1, 1: random.
    task automatic stream(input int d, input int npix, input int rmode, input int vmode);
        int sent = 0, cyc = 0, tail = 0;
        nwin = 0; done_cnt = 0; stalled_prev = 0;
        while ((sent < npix || vo[d] || tail < 2) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (sent >= npix) tail++;
            vi[d] = (sent < npix) && (vmode == 0 || $urandom_range(0, 1) == 1);
            di[d] = DW'(sent % (NC * NR));
            ri[d] = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~ri[d] : ($urandom_range(0, 3) != 0);
            #1;
            mon(d);
            if (vi[d] && ro[d]) sent++;
        end
        if (cyc >= 4000) chk("stream_timeout", 1'b1, 1'b0);
        @(negedge clk);
        vi[d] = 1'b0;
        ri[d] = 1'b1;
    endtask

    task automatic frame_checks(input int en, input int e8f, input int e8l, input int nd);
        chk("win_count", nwin, en);
        chk("first_elem8", first_e8, e8f);
        chk("first_elem0", first_e0, 0);
        chk("last_elem8", last_e8, e8l);
        chk("done_count", done_cnt, nd);
        chk("model_empty", expq.size(), 0);
    endtask

    vec_t tbl [5];

    initial begin
        tbl[0] = '{d: 0, rmode: 0, vmode: 0, npix: 48, nwin: 24, e8_first: 18, e8_last: 47, ndone: 1};
        tbl[1] = '{d: 1, rmode: 0, vmode: 0, npix: 48, nwin: 6,  e8_first: 18, e8_last: 38, ndone: 1};
        tbl[2] = '{d: 0, rmode: 1, vmode: 0, npix: 48, nwin: 24, e8_first: 18, e8_last: 47, ndone: 1};
        tbl[3] = '{d: 0, rmode: 2, vmode: 1, npix: 96, nwin: 48, e8_first: 18, e8_last: 47, ndone: 2};
        tbl[4] = '{d: 1, rmode: 2, vmode: 1, npix: 96, nwin: 12, e8_first: 18, e8_last: 38, ndone: 2};

        for (int d = 0; d < 3; d++) begin
            vi[d] = 0; ri[d] = 1; cl[d] = 0; di[d] = '0;
        end
        rst_n = 1'b0;
        check_en = 1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid_o", vo[d], 1'b0);
            chk("rst_last_o", lo[d], 1'b0);
            chk("rst_done_o", dn[d], 1'b0);
            chk("rst_window_o", wo[d], '0);
            chk("rst_coords", orow(d) + ocol(d), 0);
            chk("rst_ready_o", ro[d], 1'b1);
        end
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            build(tbl[t].d, tbl[t].npix / (NC * NR));
            stream(tbl[t].d, tbl[t].npix, tbl[t].rmode, tbl[t].vmode);
            frame_checks(tbl[t].nwin, tbl[t].e8_first, tbl[t].e8_last, tbl[t].ndone);
`ifdef CONV_SEQ_STATS_EN
            if (t == 0) begin
                chk("win_cnt", wc[0], 32'd24);
                chk("stall_cnt", sc[0], 32'd0);
            end
`endif
        end

        // Reset in mid-frame, then a full frame must start again from (0,0).
        check_en = 0;
        stream(0, 31, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_o", vo[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1;
        expq.delete();
        build(0, 1);
        stream(0, 48, 0, 0);
        frame_checks(24, 18, 47, 1);

        // Pending window dropped by clear_i; clear also beats a simultaneous accept.
        check_en = 0;
        stream(1, 18, 0, 0);
        @(negedge clk);
        vi[1] = 1; di[1] = 32'd18; ri[1] = 0;
        @(negedge clk);
        vi[1] = 0;
        #1;
        chk("pend_valid", vo[1], 1'b1);
        chk("pend_elem8", wo[1][8*DW +: DW], 18);
        chk("pend_ready_o", ro[1], 1'b0);
        @(negedge clk);
        cl[1] = 1;
        @(negedge clk);
        #1;
        chk("clr_valid_o", vo[1], 1'b0);
        chk("clr_last_o", lo[1], 1'b0);
        vi[1] = 1; ri[1] = 1; di[1] = 32'd77;
        @(negedge clk);
        cl[1] = 0; vi[1] = 0;
        check_en = 1;
        build(1, 1);
        stream(1, 48, 0, 0);
        frame_checks(6, 18, 38, 1);

        // One-shot mode: parks after the frame until clear_i.
        build(2, 1);
        stream(2, 48, 0, 0);
        frame_checks(24, 18, 47, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vi[2] = 1; di[2] = 32'd0;
            #1;
            chk("done_ready_o", ro[2], 1'b0);
            chk("done_valid_o", vo[2], 1'b0);
        end
        @(negedge clk);
        vi[2] = 0; cl[2] = 1;
        @(negedge clk);
        cl[2] = 0;
        #1;
        chk("rearm_ready_o", ro[2], 1'b1);
        build(2, 1);
        stream(2, 48, 0, 0);
        frame_checks(24, 18, 47, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
